// File: rtl/latch_wr_arbiter.sv
// rtl/latch_wr_arbiter.sv - shares one latch bank among NREQ four-phase requesters
// Optional: define LATCH_WR_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority
module latch_wr_arbiter #(
    parameter int NREQ        = 4,
    parameter int DATA_BITS   = 8,
    parameter int OPEN_CYCLES = 2,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_BITS-1:0] wdata,
    output logic [NREQ-1:0]           ack,
    output logic                      lat_en,
    output logic [DATA_BITS-1:0]      lat_d,
    output logic [IW-1:0]             grant_idx,
    output logic                      busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_OPEN,
        ST_HOLD,
        ST_ACK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            any_req;
    logic            req_g;

`ifndef LATCH_WR_ARBITER_FIXED_PRIO_EN
    logic [IW-1:0]   rr_ptr;
`endif

    // Winner selection: first requester with req high, scanning from the priority origin
    always_comb begin
        win     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_WR_ARBITER_FIXED_PRIO_EN
            cand = IW'(i);
`else
            cand = IW'((int'(rr_ptr) + i) % NREQ);
`endif
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    assign req_g = req[grant_idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the setup / enable / hold / acknowledge sequence
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_OPEN;
            ST_OPEN:  if (cnt == 4'd0) state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_ACK;
            ST_ACK:   if (!req_g) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: busy whenever a transaction is in flight
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Registered bank drive, acknowledge and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= '0;
            lat_en    <= 1'b0;
            lat_d     <= '0;
            grant_idx <= '0;
            cnt       <= '0;
`ifndef LATCH_WR_ARBITER_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Data is captured only here, so later wdata changes cannot reach the bank
                    if (any_req) begin
                        grant_idx <= win;
                        lat_d     <= wdata[int'(win)*DATA_BITS +: DATA_BITS];
                    end
                end
                ST_SETUP: begin
                    lat_en <= 1'b1;
                    cnt    <= 4'(OPEN_CYCLES - 1);
                end
                ST_OPEN: begin
                    if (cnt == 4'd0) begin
                        lat_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    ack <= {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
                end
                ST_ACK: begin
                    // A requester that dropped early still sees a one-cycle ack here
                    if (!req_g) begin
                        ack <= '0;
`ifndef LATCH_WR_ARBITER_FIXED_PRIO_EN
                        rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                    end
                end
                default: begin
                    ack    <= '0;
                    lat_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb/tb_latch_wr_arbiter.sv - scoreboard bench for latch_wr_arbiter
module tb_latch_wr_arbiter;

    localparam int K_ACK    = 0;
    localparam int K_LATEN  = 1;
    localparam int K_LATD   = 2;
    localparam int K_GIDX   = 3;
    localparam int K_BUSY   = 4;
    localparam int K_QEMPTY = 5;
    localparam int K_WAIT   = 6;
    localparam int LIMIT    = 200;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic        lat_en;
    logic [7:0]  lat_d;
    logic [1:0]  grant_idx;
    logic        busy;

    latch_wr_arbiter #(
        .NREQ(4),
        .DATA_BITS(8),
        .OPEN_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wdata(wdata),
        .ack(ack),
        .lat_en(lat_en),
        .lat_d(lat_d),
        .grant_idx(grant_idx),
        .busy(busy)
    );

    typedef struct {
        int idx;
        int data;
    } exp_t;

    typedef struct {
        int kind;
        int val;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];

    int tests      = 0;
    int fails      = 0;
    int ack_events = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: evaluates queued probes and matches each ack rise against the scoreboard
    initial begin
        logic [3:0] prev_ack;
        logic       prev_en;
        logic [7:0] prev_d;
        logic       prev_rst;
        probe_t     p;
        exp_t       e;
        prev_ack = 4'b0;
        prev_en  = 1'b0;
        prev_d   = 8'h0;
        prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.kind)
                    K_ACK:    cmp("ack", int'(ack), p.val);
                    K_LATEN:  cmp("lat_en", int'(lat_en), p.val);
                    K_LATD:   cmp("lat_d", int'(lat_d), p.val);
                    K_GIDX:   cmp("grant_idx", int'(grant_idx), p.val);
                    K_BUSY:   cmp("busy", int'(busy), p.val);
                    K_QEMPTY: cmp("scoreboard_left", exp_q.size(), p.val);
                    K_WAIT:   cmp("wait_bound", p.val, 1);
                    default:  cmp("probe_kind", p.kind, 0);
                endcase
            end
            if (!rst && !prev_rst) begin
                cmp("ack_onehot0", int'($countones(ack) <= 1), 1);
                cmp("en_d_same_cycle", int'((lat_en !== prev_en) && (lat_d !== prev_d)), 0);
            end
            if (ack != 4'b0 && prev_ack == 4'b0) begin
                ack_events++;
                if (exp_q.size() == 0) begin
                    cmp("unexpected_ack", int'(ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    cmp("grant_idx_at_ack", int'(grant_idx), e.idx);
                    cmp("ack_vector", int'(ack), 1 << e.idx);
                    cmp("lat_d_at_ack", int'(lat_d), e.data);
                end
            end
            prev_ack = ack;
            prev_en  = lat_en;
            prev_d   = lat_d;
            prev_rst = rst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pr(input int k, input int v);
        probe_t p;
        p.kind = k;
        p.val  = v;
        probe_q.push_back(p);
    endtask

    task automatic expect_grant(input int idx, input int data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            tick();
            n++;
        end
        pr(K_WAIT, int'(n < LIMIT));
    endtask

    // Requesters in mask drop req on their ack and re-raise once it falls
    task automatic run_auto(input logic [3:0] mask, input int n_acks);
        int target;
        int n;
        target = ack_events + n_acks;
        n      = 0;
        req    = mask;
        while (ack_events < target && n < LIMIT) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) req[k] = ~ack[k];
            end
            n++;
        end
        pr(K_WAIT, int'(n < LIMIT));
        req = 4'b0;
        drain();
    endtask

    task automatic wait_lat_en();
        int n;
        n = 0;
        while (!lat_en && n < LIMIT) begin
            tick();
            n++;
        end
        pr(K_WAIT, int'(n < LIMIT));
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        req   = 4'b0;
        wdata = 32'h0;

        // Reset state
        do_reset();
        pr(K_ACK, 0);
        pr(K_LATEN, 0);
        pr(K_LATD, 0);
        pr(K_GIDX, 0);
        pr(K_BUSY, 0);

        // Single write with cycle-exact timing; wdata change mid-write is ignored
        wdata[7:0] = 8'hA5;
        req        = 4'b0001;
        expect_grant(0, 'hA5);
        tick();
        pr(K_LATD, 'hA5);
        pr(K_LATEN, 0);
        pr(K_BUSY, 1);
        pr(K_GIDX, 0);
        wdata[7:0] = 8'h3C;
        tick();
        pr(K_LATEN, 1);
        pr(K_LATD, 'hA5);
        tick();
        pr(K_LATEN, 1);
        tick();
        pr(K_LATEN, 0);
        pr(K_ACK, 0);
        tick();
        pr(K_ACK, 1);
        tick();
        pr(K_ACK, 1);
        req = 4'b0;
        tick();
        pr(K_ACK, 0);
        pr(K_BUSY, 0);

        // All four requesting continuously
        do_reset();
        wdata = 32'h44332211;
`ifdef LATCH_WR_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) expect_grant(0, 'h11);
`else
        expect_grant(0, 'h11);
        expect_grant(1, 'h22);
        expect_grant(2, 'h33);
        expect_grant(3, 'h44);
        expect_grant(0, 'h11);
`endif
        run_auto(4'b1111, 5);

        // Requesters 1 and 2; requester 1 re-requests after its grant
        do_reset();
`ifdef LATCH_WR_ARBITER_FIXED_PRIO_EN
        expect_grant(1, 'h22);
        expect_grant(1, 'h22);
`else
        expect_grant(1, 'h22);
        expect_grant(2, 'h33);
`endif
        run_auto(4'b0110, 2);

        // Reset while lat_en is high aborts the write without an ack
        req = 4'b1000;
        wait_lat_en();
        rst = 1'b1;
        tick();
        pr(K_LATEN, 0);
        pr(K_ACK, 0);
        pr(K_BUSY, 0);
        pr(K_GIDX, 0);
        rst = 1'b0;
        expect_grant(1, 'h22);
        run_auto(4'b1010, 1);

        // Requester 3 drops req during OPEN: write completes, one-cycle ack
        wdata = 32'h5A332211;
        req   = 4'b1000;
        expect_grant(3, 'h5A);
        wait_lat_en();
        req = 4'b0;
        n   = 0;
        while (ack == 4'b0 && n < LIMIT) begin
            tick();
            n++;
        end
        pr(K_WAIT, int'(n < LIMIT));
        pr(K_ACK, 8);
        tick();
        pr(K_ACK, 0);
        pr(K_BUSY, 0);

        pr(K_QEMPTY, 0);
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
